rc4_keystream_gen: RTL

//  Parametrised RC4 keystream generator; successor to the fixed 4-byte-key rc4 core.
//  - Runtime key length up to KEY_BYTES_MAX.
//  - Continuous PRGA output behind a valid/ready handshake with back-pressure.
//  - Restartable via stop; optional RC4-drop[N] discard of early keystream.
//  - Sits between the key/config register block and the stream XOR datapath.

---
 rtl/rc4_keystream_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rc4_keystream_gen.sv
`default_nettype none
// rc4_keystream_gen: RC4 keystream generator with runtime key length and a valid/ready output.
// Optional RC4-drop[N] discard is enabled by defining RC4_DROP_EN. Rev 1.0
module rc4_keystream_gen #(
   parameter int KEY_BYTES_MAX = 16,
   parameter int DROP_N        = 768,
   parameter int CNT_W         = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       stop,
   input  logic [8*KEY_BYTES_MAX-1:0] key,
   input  logic [7:0]                 key_len,
   output logic [7:0]                 ks_byte,
   output logic                       ks_valid,
   input  logic                       ks_ready,
   output logic                       busy,
   output logic [CNT_W-1:0]           ks_count
);

   localparam int KIDX_W = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      KSA  = 3'd2,
`ifdef RC4_DROP_EN
      DROP = 3'd4,
`endif
      PRGA = 3'd3
   } state_t;

   state_t                     state;
   logic [7:0]                 s [256];
   logic [7:0]                 i;
   logic [7:0]                 j;
   logic [8*KEY_BYTES_MAX-1:0] key_reg;
   logic [KIDX_W-1:0]          kidx;
   logic [KIDX_W-1:0]          len_m1;
   logic [KIDX_W-1:0]          len_m1_in;

`ifdef RC4_DROP_EN
   localparam int DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
   logic [DROP_W-1:0]          drop_cnt;
`endif

   logic [7:0] key_byte;
   logic [7:0] idx_a;
   logic [7:0] sa;
   logic [7:0] sb;
   logic [7:0] j_new;
   logic [7:0] t;
   logic [7:0] k;
   logic       step_prga;

   always_comb begin
      len_m1_in = KIDX_W'(KEY_BYTES_MAX - 1);
      if (key_len != 8'd0 && 32'(key_len) <= 32'(KEY_BYTES_MAX))
         len_m1_in = KIDX_W'(key_len - 8'd1);
   end

   // One datapath serves KSA (index i) and PRGA/DROP (index i+1); the key term is KSA-only.
   always_comb begin
      key_byte = key_reg[8*kidx +: 8];
      idx_a    = (state == KSA) ? i : i + 8'd1;
      sa       = s[idx_a];
      j_new    = j + sa + ((state == KSA) ? key_byte : 8'd0);
      sb       = s[j_new];
      t        = sa + sb;
      // Output lookup sees the post-swap array, so forward the two swapped entries.
      if (t == idx_a)
         k = sb;
      else if (t == j_new)
         k = sa;
      else
         k = s[t];
      step_prga = (state == PRGA) && (!ks_valid || ks_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ks_byte  <= 8'd0;
         ks_valid <= 1'b0;
         busy     <= 1'b0;
         ks_count <= '0;
         i        <= 8'd0;
         j        <= 8'd0;
         key_reg  <= '0;
         kidx     <= '0;
         len_m1   <= '0;
`ifdef RC4_DROP_EN
         drop_cnt <= '0;
`endif
      end else if (stop) begin
         state    <= IDLE;
         ks_valid <= 1'b0;
         busy     <= 1'b0;
         i        <= 8'd0;
         j        <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key_reg  <= key;
                  len_m1   <= len_m1_in;
                  ks_count <= '0;
                  i        <= 8'd0;
                  j        <= 8'd0;
                  kidx     <= '0;
                  busy     <= 1'b1;
                  state    <= INIT;
               end
            end
            INIT: begin
               s[i] <= i;
               i    <= i + 8'd1;
               if (i == 8'd255) begin
                  j     <= 8'd0;
                  state <= KSA;
               end
            end
            KSA: begin
               s[idx_a] <= sb;
               s[j_new] <= sa;
               i        <= i + 8'd1;
               kidx     <= (kidx == len_m1) ? '0 : kidx + 1'b1;
               if (i == 8'd255) begin
                  j <= 8'd0;
`ifdef RC4_DROP_EN
                  drop_cnt <= '0;
                  state    <= (DROP_N == 0) ? PRGA : DROP;
`else
                  state    <= PRGA;
`endif
               end else begin
                  j <= j_new;
               end
            end
`ifdef RC4_DROP_EN
            DROP: begin
               s[idx_a] <= sb;
               s[j_new] <= sa;
               i        <= idx_a;
               j        <= j_new;
               if (drop_cnt == DROP_W'(DROP_N - 1))
                  state <= PRGA;
               else
                  drop_cnt <= drop_cnt + 1'b1;
            end
`endif
            PRGA: begin
               if (ks_valid && ks_ready)
                  ks_count <= ks_count + 1'b1;
               if (step_prga) begin
                  s[idx_a] <= sb;
                  s[j_new] <= sa;
                  i        <= idx_a;
                  j        <= j_new;
                  ks_byte  <= k;
                  ks_valid <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               ks_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
